// File: rtl/pio_bidir_irq.sv
// Bidirectional PIO with a memory-mapped register file, an input synchronizer and
// edge-capture interrupts. Register reads are combinational and have no side effects.
module pio_bidir_irq #(
   parameter int WIDTH       = 10,
   parameter int RESET_VALUE = 239,
   parameter int DIR_RESET   = 0,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   localparam logic [31:0]      RV32     = 32'(RESET_VALUE);
   localparam logic [31:0]      DV32     = 32'(DIR_RESET);
   localparam logic [WIDTH-1:0] RST_DATA = RV32[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST_DIR  = DV32[WIDTH-1:0];

   typedef enum logic [2:0] {
      A_DATA = 3'd0, A_DIR = 3'd1, A_MASK = 3'd2, A_ECAP = 3'd3,
      A_OSET = 3'd4, A_OCLR = 3'd5
   } addr_e;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_in, prev_in, edge_evt, ec_clr;
   logic [WIDTH-1:0] data_out, dir, irqmask, edgecap, wd, rd;
   logic             wr_en;
   logic             unused_wd;

   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = &{1'b0, writedata};
   assign wr_en     = chipselect & ~write_n;
   assign sync_in   = sync_q[SYNC_STAGES-1];
   assign ec_clr    = (wr_en && address == A_ECAP) ? wd : '0;

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edge_evt = sync_in & ~prev_in;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edge_evt = ~sync_in & prev_in;
      end else begin : g_any
         assign edge_evt = sync_in ^ prev_in;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q   <= '0;
         prev_in  <= '0;
         data_out <= RST_DATA;
         dir      <= RST_DIR;
         irqmask  <= '0;
         edgecap  <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
         prev_in <= sync_in;
         // set has priority over a simultaneous write-1-to-clear
         edgecap <= (edgecap & ~ec_clr) | edge_evt;
         if (wr_en) begin
            case (address)
               A_DATA:  data_out <= wd;
               A_DIR:   dir      <= wd;
               A_MASK:  irqmask  <= wd;
               A_OSET:  data_out <= data_out | wd;
               A_OCLR:  data_out <= data_out & ~wd;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd = '0;
      case (address)
         A_DATA:  rd = (sync_in & ~dir) | (data_out & dir);
         A_DIR:   rd = dir;
         A_MASK:  rd = irqmask;
         A_ECAP:  rd = edgecap;
         default: rd = '0;
      endcase
      readdata            = '0;
      readdata[WIDTH-1:0] = rd;
   end

   assign out_port = data_out;
   assign oe       = dir;
   assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Directed bench: a default 10-bit PIO plus a 32-bit instance sharing the bus
// for the full-width mixed-direction read.
module tb_pio_bidir_irq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata, rd32;
   logic [9:0]  in_port, out_port, oe;
   logic [31:0] in32, out32, oe32;
   logic        irq, irq32;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pio_bidir_irq dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
   );

   pio_bidir_irq #(.WIDTH(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd32),
      .in_port(in32), .out_port(out32), .oe(oe32), .irq(irq32)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      @(negedge clk);
      address = a; #1;
      check(tag, readdata, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0; in32 = '0;
      #12;
      check("rst_out_port", 32'(out_port), 32'h0EF);
      check("rst_oe", 32'(oe), 32'h000);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_read_data", readdata, 32'h0);

      @(negedge clk); reset_n = 1'b1;
      cycles(4);

      // set/clear sequence
      wr(3'd1, 32'h3FF);
      wr(3'd0, 32'h000);
      wr(3'd4, 32'h005);
      wr(3'd5, 32'h004);
      check("setclr_out_port", 32'(out_port), 32'h001);
      check("setclr_oe", 32'(oe), 32'h3FF);
      rd_chk("setclr_read_data", 3'd0, 32'h1);
      rd_chk("read_outset", 3'd4, 32'h0);
      rd_chk("read_outclr", 3'd5, 32'h0);
      rd_chk("read_addr6", 3'd6, 32'h0);
      rd_chk("read_addr7", 3'd7, 32'h0);

      // rising edge on bit 1 -> EDGECAP exactly 3 cycles later
      wr(3'd2, 32'h002);
      rd_chk("irqmask_rb", 3'd2, 32'h002);
      @(negedge clk); in_port = 10'h002; address = 3'd3;
      cycles(1);
      check("ecap_lat1", readdata, 32'h0);
      cycles(1);
      check("ecap_lat2", readdata, 32'h0);
      check("irq_lat2", 32'(irq), 32'h0);
      cycles(1);
      check("ecap_lat3", readdata, 32'h002);
      check("irq_lat3", 32'(irq), 32'h1);
      wr(3'd3, 32'h002);
      check("irq_after_w1c", 32'(irq), 32'h0);
      rd_chk("ecap_after_w1c", 3'd3, 32'h0);

      // capture again, then drop pin: falling edge must not capture
      @(negedge clk); in_port = 10'h000;
      cycles(4);
      rd_chk("no_fall_capture", 3'd3, 32'h0);
      @(negedge clk); in_port = 10'h002;
      cycles(4);
      rd_chk("recapture", 3'd3, 32'h002);
      @(negedge clk); in_port = 10'h000;
      cycles(4);

      // collision: W1C lands on the same edge that sets the bit
      @(negedge clk); in_port = 10'h002;
      cycles(2);
      wr(3'd3, 32'h002);
      check("collision_irq", 32'(irq), 32'h1);
      rd_chk("collision_ecap", 3'd3, 32'h002);
      wr(3'd3, 32'h002);
      rd_chk("clear_after_collision", 3'd3, 32'h0);

      // width truncation and mixed direction on the 10-bit part
      wr(3'd0, 32'hFFFF_FFFF);
      rd_chk("data_trunc", 3'd0, 32'h3FF);
      wr(3'd1, 32'h0F0);
      @(negedge clk); in_port = 10'h005;
      cycles(3);
      rd_chk("mixed_dir10", 3'd0, 32'h0F5);

      // 32-bit instance mixed direction
      wr(3'd1, 32'hFFFF_0000);
      wr(3'd0, 32'hABCD_1234);
      @(negedge clk); in32 = 32'h5555_AAAA;
      cycles(3);
      @(negedge clk); address = 3'd0; #1;
      check("mixed_dir32", rd32, 32'hABCD_AAAA);
      check("dir_trunc10", 32'(oe), 32'h000);

      // fill EDGECAP and irq, then reset mid-operation
      wr(3'd2, 32'h3FF);
      @(negedge clk); in_port = 10'h3FF;
      cycles(4);
      rd_chk("ecap_full", 3'd3, 32'h3FF);
      check("irq_full", 32'(irq), 32'h1);
      @(negedge clk); reset_n = 1'b0; #1;
      check("midrst_irq", 32'(irq), 32'h0);
      check("midrst_out_port", 32'(out_port), 32'h0EF);
      address = 3'd3; #1;
      check("midrst_ecap", readdata, 32'h0);
      address = 3'd2; #1;
      check("midrst_mask", readdata, 32'h0);

      // pin held high through reset: captured once after synchronizer fill
      @(negedge clk); reset_n = 1'b1; address = 3'd3;
      cycles(1);
      check("fill_cyc1", readdata, 32'h0);
      cycles(1);
      check("fill_cyc2", readdata, 32'h0);
      cycles(1);
      check("fill_cyc3", readdata, 32'h3FF);
      check("fill_irq_masked", 32'(irq), 32'h0);
      wr(3'd3, 32'h3FF);
      cycles(3);
      rd_chk("fill_once", 3'd3, 32'h0);

      // writes without chipselect are ignored
      @(negedge clk); address = 3'd1; writedata = 32'h3FF; write_n = 1'b0; chipselect = 1'b0;
      @(posedge clk); #1; write_n = 1'b1;
      rd_chk("no_cs_write", 3'd1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pio_bidir_irq.md
PIO_BIDIR_IRQ -- requirements
Module: pio_bidir_irq

Interface
REQ-001 Parameter WIDTH, default 10: number of PIO bits, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 239: reset value of the output data register, truncated to WIDTH.
REQ-003 Parameter DIR_RESET, default 0: reset value of the direction register, where a 1 bit means output.
REQ-004 Parameter EDGE_TYPE, default 0: edge that is captured, where 0 = rising, 1 = falling, 2 = any.
REQ-005 Parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..3.
REQ-006 clk  in  1  single clock; all state SHALL be clocked on the rising edge.
REQ-007 reset_n  in  1  reset, asynchronous and active-low.
REQ-008 address  in  3  word register select.
REQ-009 chipselect  in  1  slave select.
REQ-010 write_n  in  1  active-low write strobe.
REQ-011 writedata  in  32  write data.
REQ-012 readdata  out  32  read data, combinational, zero-extended above WIDTH.
REQ-013 in_port  in  WIDTH  asynchronous pin input.
REQ-014 out_port  out  WIDTH  output data register.
REQ-015 oe  out  WIDTH  per-bit output enable, equal to the direction register.
REQ-016 irq  out  1  level interrupt, active-high.

Function
REQ-017 A write SHALL occur when chipselect=1 and write_n=0; it SHALL take effect on that clock edge, using writedata[WIDTH-1:0].
REQ-018 Register map (R = read, W = write):
- addr 0 DATA: R = (sync_in & ~dir) | (data_out & dir); W = data_out.
- addr 1 DIR: R/W.
- addr 2 IRQMASK: R/W.
- addr 3 EDGECAP: R; a written 1 clears the corresponding bit.
- addr 4 OUTSET: W only; data_out |= wd; reads 0.
- addr 5 OUTCLR: W only; data_out &= ~wd; reads 0.
- addr 6-7: reads 0, writes ignored.
REQ-019 in_port SHALL pass through a SYNC_STAGES-flop synchronizer to form sync_in, plus one additional delay register prev_in for edge detection.
REQ-020 The edge event for bit i SHALL be:
- rising: sync_in & ~prev_in
- falling: ~sync_in & prev_in
- any: sync_in ^ prev_in
REQ-021 Edge capture SHALL apply to all bits regardless of DIR.
REQ-022 A detected edge SHALL set the EDGECAP bit on the next clock edge; latency from a pin change to EDGECAP set SHALL be SYNC_STAGES+1 cycles.
REQ-023 When an edge event and a write-1-to-clear hit the same bit in the same cycle, the set SHALL win (the bit stays 1).
REQ-024 irq SHALL equal OR-reduce(EDGECAP & IRQMASK) combinationally from registered state; it stays asserted until the EDGECAP bit is cleared or masked.
REQ-025 Reads SHALL have zero wait states, and readdata SHALL be valid in the same cycle as address; reads SHALL have no side effects.
REQ-026 Writes with chipselect=0 SHALL be ignored.
REQ-027 writedata bits at and above WIDTH SHALL be ignored.
REQ-028 readdata bits at and above WIDTH SHALL read 0.
REQ-029 If OUTSET and OUTCLR target the same bit, the operations are on different addresses and SHALL apply sequentially, in write order.

Reset
REQ-030 On reset_n=0, asynchronously:
- data_out = RESET_VALUE
- DIR = DIR_RESET
- IRQMASK = 0
- EDGECAP = 0
- synchronizer and prev_in = 0
REQ-031 While in reset: out_port = RESET_VALUE, oe = DIR_RESET, irq = 0.
REQ-032 No edge SHALL be captured in the first SYNC_STAGES+1 cycles after reset release due to synchronizer fill from 0; a pin held high through reset therefore SHALL produce a rising edge capture once.
REQ-033 Reset asserted mid-operation SHALL discard pending edges and deassert irq immediately.

Verification
REQ-034 Reset: apply reset_n=0 -> out_port=0x0EF, oe=0x000, irq=0, read addr 0 returns in_port-synced value with all bits input.
REQ-035 Set/clear:
- write DIR=0x3FF, DATA=0x000, OUTSET=0x005, OUTCLR=0x004 -> out_port=0x001, read addr 0 = 0x00000001.
REQ-036 Edge and irq, EDGE_TYPE=0:
- write IRQMASK=0x002, raise in_port[1] -> EDGECAP=0x002 exactly 3 cycles later, irq=1.
- write EDGECAP=0x002 -> irq=0 the next cycle.
REQ-037 Collision: a write-1-to-clear of EDGECAP bit 1 in the same cycle as a new rising edge on bit 1 -> the bit remains 1 and irq remains 1.
REQ-038 Width/mixed direction:
- WIDTH=32, DIR=0xFFFF0000, data_out=0xABCD1234, in_port=0x5555AAAA -> read addr 0 = 0xABCDAAAA.
- WIDTH=10 write 0xFFFFFFFF to DATA -> readback 0x000003FF.
REQ-039 Reset mid-operation: with EDGECAP=0x3FF and irq=1, pulse reset_n low -> EDGECAP=0, IRQMASK=0, and irq=0 asynchronously.
